// File: rtl/rom_burst_reader_pkg.sv
// Shared definitions for the program-ROM burst reader: default widths and FSM state encoding.
package rom_burst_reader_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_burst_reader_if.sv
// Command, ROM bus and output stream signals of the burst reader; master is the reader side.
interface rom_burst_reader_if
  import rom_burst_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, length, rom_data, dout_ready,
    output rom_addr, dout, dout_valid, busy, done
  );

  modport slave (
    output start, base_addr, length, rom_data, dout_ready,
    input  rom_addr, dout, dout_valid, busy, done
  );

endinterface

// File: rtl/rom_burst_reader_addr_counter.sv
// Loadable wrap-around address counter; load wins over inc, wraps modulo 2**ADDR_W.
module rom_burst_reader_addr_counter
  import rom_burst_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= q + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst sequencer for the program ROM: reads length bytes from base_addr and streams them out.
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  rom_burst_reader_if.master  bus
);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  count;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              addr_load;
  logic              addr_inc;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              accept;
  logic              handshake;

  assign accept    = (state == ST_IDLE) && bus.start && (bus.length != '0);
  assign handshake = (state == ST_SEND) && bus.dout_ready;

  rom_burst_reader_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk      (clk),
    .rst      (reset),
    .load     (addr_load),
    .inc      (addr_inc),
    .load_val (bus.base_addr),
    .q        (rom_addr_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_load = 1'b0;
    addr_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          addr_load = 1'b1;
          state_nxt = ST_FETCH;
        end else if (bus.start) begin
          state_nxt = ST_DONE;
        end
      end
      ST_FETCH: state_nxt = ST_SEND;
      ST_SEND: begin
        if (handshake) begin
          // The last byte leaves rom_addr on its own address rather than advancing.
          if (count == LEN_W'(1)) begin
            state_nxt = ST_DONE;
          end else begin
            addr_inc  = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        count <= bus.length;
      end
      if (state == ST_FETCH) begin
        dout_q       <= bus.rom_data;
        dout_valid_q <= 1'b1;
      end
      if (handshake) begin
        dout_valid_q <= 1'b0;
        count        <= count - LEN_W'(1);
      end
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader with a ROM model returning addr[7:0] ^ 8'h5A.
module tb_rom_burst_reader;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  rom_burst_reader_if #(.ADDR_W(12), .DATA_W(8), .LEN_W(13)) bus ();

  assign bus.rom_data = bus.rom_addr[7:0] ^ 8'h5A;

  rom_burst_reader #(
    .ADDR_W (12),
    .DATA_W (8),
    .LEN_W  (13)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a valid byte, checks it and its address, then lets one edge
  // complete the handshake with dout_ready held high.
  task automatic expect_byte(input string tag, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data);
    int w;
    w = 0;
    while (!bus.dout_valid && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_valid"}, 32'(bus.dout_valid), 1);
    chk({tag, "_addr"}, 32'(bus.rom_addr), exp_addr);
    chk({tag, "_dout"}, 32'(bus.dout), exp_data);
    bus.dout_ready = 1'b1;
    tick();
    chk({tag, "_consumed"}, 32'(bus.dout_valid), 0);
  endtask

  task automatic start_burst(input logic [11:0] base, input logic [12:0] len);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = len;
    tick();
    bus.start     = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int errs;
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.length     = '0;
    bus.dout_ready = 1'b1;
    tick();
    tick();
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_valid", 32'(bus.dout_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    reset = 1'b0;
    tick();

    // 1: plain burst from address 0
    start_burst(12'h000, 13'd4);
    chk("t1_fetch_busy", 32'(bus.busy), 1);
    chk("t1_fetch_valid", 32'(bus.dout_valid), 0);
    tick();
    chk("t1_first_valid", 32'(bus.dout_valid), 1);
    expect_byte("t1_b0", 'h000, 'h5A);
    expect_byte("t1_b1", 'h001, 'h5B);
    expect_byte("t1_b2", 'h002, 'h58);
    expect_byte("t1_b3", 'h003, 'h59);
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_done_busy", 32'(bus.busy), 1);
    tick();
    chk("t1_done_clear", 32'(bus.done), 0);
    chk("t1_idle_busy", 32'(bus.busy), 0);

    // 2: wrap-around at top of ROM
    start_burst(12'hFFE, 13'd4);
    expect_byte("t2_b0", 'hFFE, 'hA4);
    expect_byte("t2_b1", 'hFFF, 'hA5);
    expect_byte("t2_b2", 'h000, 'h5A);
    expect_byte("t2_b3", 'h001, 'h5B);
    chk("t2_done", 32'(bus.done), 1);
    tick();
    chk("t2_idle_busy", 32'(bus.busy), 0);

    // 3: zero-length burst
    start_burst(12'h123, 13'd0);
    chk("t3_done", 32'(bus.done), 1);
    chk("t3_busy", 32'(bus.busy), 1);
    chk("t3_valid", 32'(bus.dout_valid), 0);
    tick();
    chk("t3_done_clear", 32'(bus.done), 0);
    chk("t3_idle_busy", 32'(bus.busy), 0);
    chk("t3_idle_valid", 32'(bus.dout_valid), 0);

    // 4: consumer stall on the second byte
    start_burst(12'h010, 13'd3);
    expect_byte("t4_b0", 'h010, 'h4A);
    bus.dout_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_valid", 32'(bus.dout_valid), 1);
      chk("t4_stall_dout", 32'(bus.dout), 'h4B);
      chk("t4_stall_busy", 32'(bus.busy), 1);
      tick();
    end
    expect_byte("t4_b1", 'h011, 'h4B);
    expect_byte("t4_b2", 'h012, 'h48);
    chk("t4_done", 32'(bus.done), 1);
    tick();
    chk("t4_idle_valid", 32'(bus.dout_valid), 0);

    // 5: start and operand changes mid-burst are ignored
    start_burst(12'h020, 13'd3);
    expect_byte("t5_b0", 'h020, 'h7A);
    start_burst(12'h100, 13'd5);
    expect_byte("t5_b1", 'h021, 'h7B);
    expect_byte("t5_b2", 'h022, 'h78);
    chk("t5_done", 32'(bus.done), 1);
    tick();
    tick();
    chk("t5_no_restart", 32'(bus.busy), 0);
    chk("t5_final_addr", 32'(bus.rom_addr), 'h022);

    // 6: reset in the middle of a stalled burst, then a fresh burst
    bus.dout_ready = 1'b0;
    start_burst(12'h030, 13'd8);
    tick();
    chk("t6_in_send", 32'(bus.dout_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_valid", 32'(bus.dout_valid), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_addr", 32'(bus.rom_addr), 0);
    chk("t6_rst_dout", 32'(bus.dout), 0);
    bus.dout_ready = 1'b1;
    start_burst(12'h005, 13'd2);
    expect_byte("t6_b0", 'h005, 'h5F);
    expect_byte("t6_b1", 'h006, 'h5C);
    chk("t6_done", 32'(bus.done), 1);
    tick();

    // 7: full-ROM burst visits every address once and stops on 12'hFFF
    start_burst(12'h000, 13'd4096);
    errs = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (!bus.dout_valid || bus.rom_addr != 12'(i) ||
          bus.dout != (8'(i) ^ 8'h5A)) begin
        errs++;
      end
      tick();
    end
    chk("t7_byte_errors", 32'(errs), 0);
    chk("t7_done", 32'(bus.done), 1);
    chk("t7_last_addr", 32'(bus.rom_addr), 'hFFF);
    tick();
    chk("t7_idle_busy", 32'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
